branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumes compare results on behalf of the fetch stage: resolves MIPS branch and jump instructions issued from EX and produces a PC redirect, a link write and a flush request.
- Sits between the EX-stage operand bus and the fetch unit.
- Uses a valid/ready handshake on the issue side and a hold-until-accept handshake on the redirect side.

Parameters:
BITS, 32, operand width for a and b
ADDR_BITS, 32, program-counter width (must be >= 28)
COUNT_BITS, 16, width of saturating taken-branch counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
issueValid  input  1  branch op presented
issueReady  output  1  block can accept an op
op  input  4  branch_op_t encoding
a  input  BITS  rs operand
b  input  BITS  rt operand
pc  input  ADDR_BITS  address of the branch instruction
offset  input  16  raw immediate, sign-extended internally
target26  input  26  jump index field
redirectValid  output  1  redirect pending to fetch
redirectTarget  output  ADDR_BITS  new PC
redirectAccept  input  1  fetch consumed redirect
flush  output  1  one-cycle pulse: kill wrong-path instructions
linkValid  output  1  one-cycle pulse: write linkAddress to $ra or rd
linkAddress  output  ADDR_BITS  pc + 8
illegalOp  output  1  one-cycle pulse on an unknown op
takenCount  output  COUNT_BITS  saturating count of taken branches and jumps

Behaviour:
- Clock and reset are fixed: single clock clk; reset is synchronous and active-high.
- Reset values:
  - State IDLE; issueReady=1.
  - redirectValid, flush, linkValid and illegalOp are 0.
  - redirectTarget, linkAddress and takenCount are 0.
  - Reset asserted in any state, including REDIRECT with a pending redirect, drops everything on the next edge with no flush.
- States:
  - IDLE:
    - issueReady=1.
    - On issueValid, latch op, a, b, pc, offset and target26, then go to EVAL.
  - EVAL (one cycle):
    - issueReady=0.
    - Evaluate the condition on the latched operands using signed compare only:
      - BEQ: a==b
      - BNE: a!=b
      - BLEZ: a<=0
      - BGTZ: a>0
      - BLTZ and BLTZAL: a<0
      - BGEZ and BGEZAL: a>=0
      - J, JAL, JR and JALR: always taken.
    - Targets:
      - Branches: pc+4+(sext(offset)<<2), wrapping mod 2^ADDR_BITS.
      - J and JAL: {(pc+4)[ADDR_BITS-1:28], target26, 2'b00}.
      - JR and JALR: a[ADDR_BITS-1:0].
    - Link: linkValid pulses in EVAL for BLTZAL, BGEZAL, JAL and JALR whether the branch is taken or not, with linkAddress=pc+8.
    - If taken: register redirectTarget, set redirectValid=1 and increment takenCount (saturating at all-ones), then go to REDIRECT.
    - If not taken: go to IDLE; redirectValid stays 0.
    - Unknown op: illegalOp pulses, the op is treated as not taken with no link, and the state goes to IDLE.
  - REDIRECT:
    - redirectValid=1, redirectTarget held stable, issueReady=0; issueValid is ignored.
    - On redirectAccept: flush pulses on that same cycle, then the next state is IDLE with redirectValid=0.
    - If redirectAccept is already high on entry, the redirect completes after exactly one REDIRECT cycle.
- Latency:
  - Taken branch: issue edge to redirectValid is 2 edges.
  - Not-taken branch: the block is ready again 2 edges after issue.
- Throughput: at most one op per 2 cycles. redirectAccept outside REDIRECT is ignored.

Decomposition:
- Package branch_pkg holds:
  - branch_op_t, a 4-bit enum: BEQ=0, BNE=1, BLEZ=2, BGTZ=3, BLTZ=4, BGEZ=5, BLTZAL=6, BGEZAL=7, J=8, JAL=9, JR=10, JALR=11; 12-15 are illegal.
  - The state enum.
  - Helper functions isLinkOp and isUnconditional.
- One combinational sub-module, branch_condition: takes op, a and b and returns taken and legal. It is kept separate so it can be unit-tested exhaustively.

Test Plan:
- BEQ, a=5, b=5, pc=0x0040_0000, offset=0x0004 -> redirectValid on 2nd edge, redirectTarget=0x0040_0014; redirectAccept=1 -> flush pulse, back to IDLE; takenCount=1.
- BNE, a=5, b=5 -> no redirect, no flush, issueReady high again after 2 edges, takenCount unchanged.
- BLTZAL, a=0x0000_0001, pc=0x100 -> not taken, linkValid pulse with linkAddress=0x108, no redirect. Repeat with a=0xFFFF_FFFF, offset=0xFFFF -> taken, target=0x100.
- JAL, pc=0x9000_0000, target26=0x0000010 -> redirectTarget=0x9000_0040, linkAddress=0x9000_0008. Hold redirectAccept=0 for 5 cycles -> target stable, issueValid ignored, then accept.
- Reset pulsed mid-REDIRECT -> redirectValid=0 next edge, no flush, issueReady=1. Op=14 -> illegalOp pulse, no redirect.
- Issue 0xFFFF+2 taken J ops -> takenCount saturates at 0xFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: op encoding, FSM states
// and op-class helpers used by the resolver and its condition unit.
package branch_pkg;

   typedef enum logic [3:0] {
      OP_BEQ    = 4'd0,
      OP_BNE    = 4'd1,
      OP_BLEZ   = 4'd2,
      OP_BGTZ   = 4'd3,
      OP_BLTZ   = 4'd4,
      OP_BGEZ   = 4'd5,
      OP_BLTZAL = 4'd6,
      OP_BGEZAL = 4'd7,
      OP_J      = 4'd8,
      OP_JAL    = 4'd9,
      OP_JR     = 4'd10,
      OP_JALR   = 4'd11
   } branch_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EVAL,
      S_REDIRECT
   } state_t;

   function automatic logic isLinkOp(logic [3:0] op);
      return (op == OP_BLTZAL) || (op == OP_BGEZAL) ||
             (op == OP_JAL)    || (op == OP_JALR);
   endfunction

   function automatic logic isUnconditional(logic [3:0] op);
      return (op == OP_J)  || (op == OP_JAL) ||
             (op == OP_JR) || (op == OP_JALR);
   endfunction

endpackage

// File: rtl/branch_condition.sv
// Combinational branch condition unit: signed compare of a/b per op.
// Ports: op (4b), a, b (BITS) in; taken, legal out.
module branch_condition
   import branch_pkg::*;
#(
   parameter int BITS = 32
) (
   input  logic [3:0]      op,
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   output logic            taken,
   output logic            legal
);

   logic neg;
   logic zero;

   assign neg  = a[BITS-1];
   assign zero = (a == '0);

   always_comb begin
      taken = 1'b0;
      legal = 1'b1;
      if (isUnconditional(op)) begin
         taken = 1'b1;
      end else begin
         case (op)
            OP_BEQ:    taken = (a == b);
            OP_BNE:    taken = (a != b);
            OP_BLEZ:   taken = neg | zero;
            OP_BGTZ:   taken = ~neg & ~zero;
            OP_BLTZ,
            OP_BLTZAL: taken = neg;
            OP_BGEZ,
            OP_BGEZAL: taken = ~neg;
            default:   legal = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolver.sv
// Resolves EX-stage branches/jumps into a held fetch redirect, a link
// pulse, a flush pulse and a saturating taken counter.
// Ports: clk/reset; issue handshake + operands; redirect handshake;
// flush, linkValid/linkAddress, illegalOp, takenCount.
module branch_resolver
   import branch_pkg::*;
#(
   parameter int BITS       = 32,
   parameter int ADDR_BITS  = 32,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  issueValid,
   output logic                  issueReady,
   input  logic [3:0]            op,
   input  logic [BITS-1:0]       a,
   input  logic [BITS-1:0]       b,
   input  logic [ADDR_BITS-1:0]  pc,
   input  logic [15:0]           offset,
   input  logic [25:0]           target26,
   output logic                  redirectValid,
   output logic [ADDR_BITS-1:0]  redirectTarget,
   input  logic                  redirectAccept,
   output logic                  flush,
   output logic                  linkValid,
   output logic [ADDR_BITS-1:0]  linkAddress,
   output logic                  illegalOp,
   output logic [COUNT_BITS-1:0] takenCount
);

   state_t                state_q, state_d;
   logic [3:0]            op_q, op_d;
   logic [BITS-1:0]       a_q, a_d;
   logic [BITS-1:0]       b_q, b_d;
   logic [ADDR_BITS-1:0]  pc_q, pc_d;
   logic [15:0]           offset_q, offset_d;
   logic [25:0]           t26_q, t26_d;
   logic                  redirectValid_q, redirectValid_d;
   logic [ADDR_BITS-1:0]  redirectTarget_q, redirectTarget_d;
   logic [ADDR_BITS-1:0]  linkAddress_q, linkAddress_d;
   logic [COUNT_BITS-1:0] takenCount_q, takenCount_d;

   logic                  taken;
   logic                  legal;
   logic [ADDR_BITS-1:0]  pc4;
   logic [ADDR_BITS-1:0]  boff;
   logic [ADDR_BITS-1:0]  target;

   branch_condition #(.BITS(BITS)) u_cond (
      .op    (op_q),
      .a     (a_q),
      .b     (b_q),
      .taken (taken),
      .legal (legal)
   );

   always_comb begin
      pc4  = pc_q + ADDR_BITS'(4);
      boff = {{(ADDR_BITS-18){offset_q[15]}}, offset_q, 2'b00};
      if (op_q == OP_JR || op_q == OP_JALR) begin
         target = a_q[ADDR_BITS-1:0];
      end else if (op_q == OP_J || op_q == OP_JAL) begin
         // Keep the upper PC bits of the delay slot, replace [27:0].
         target       = pc4;
         target[27:0] = {t26_q, 2'b00};
      end else begin
         target = pc4 + boff;
      end
   end

   always_comb begin
      state_d          = state_q;
      op_d             = op_q;
      a_d              = a_q;
      b_d              = b_q;
      pc_d             = pc_q;
      offset_d         = offset_q;
      t26_d            = t26_q;
      redirectValid_d  = redirectValid_q;
      redirectTarget_d = redirectTarget_q;
      linkAddress_d    = linkAddress_q;
      takenCount_d     = takenCount_q;
      case (state_q)
         S_IDLE: begin
            if (issueValid) begin
               op_d          = op;
               a_d           = a;
               b_d           = b;
               pc_d          = pc;
               offset_d      = offset;
               t26_d         = target26;
               linkAddress_d = pc + ADDR_BITS'(8);
               state_d       = S_EVAL;
            end
         end
         S_EVAL: begin
            if (taken) begin
               redirectTarget_d = target;
               redirectValid_d  = 1'b1;
               if (takenCount_q != '1) begin
                  takenCount_d = takenCount_q + 1'b1;
               end
               state_d = S_REDIRECT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_REDIRECT: begin
            if (redirectAccept) begin
               redirectValid_d = 1'b0;
               state_d         = S_IDLE;
            end
         end
         default: begin
            redirectValid_d = 1'b0;
            state_d         = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         op_q             <= '0;
         a_q              <= '0;
         b_q              <= '0;
         pc_q             <= '0;
         offset_q         <= '0;
         t26_q            <= '0;
         redirectValid_q  <= 1'b0;
         redirectTarget_q <= '0;
         linkAddress_q    <= '0;
         takenCount_q     <= '0;
      end else begin
         state_q          <= state_d;
         op_q             <= op_d;
         a_q              <= a_d;
         b_q              <= b_d;
         pc_q             <= pc_d;
         offset_q         <= offset_d;
         t26_q            <= t26_d;
         redirectValid_q  <= redirectValid_d;
         redirectTarget_q <= redirectTarget_d;
         linkAddress_q    <= linkAddress_d;
         takenCount_q     <= takenCount_d;
      end
   end

   // Pulses are gated by reset so a reset cycle never flushes or links.
   assign issueReady     = (state_q == S_IDLE);
   assign flush          = (state_q == S_REDIRECT) & redirectAccept & ~reset;
   assign linkValid      = (state_q == S_EVAL) & legal & isLinkOp(op_q) & ~reset;
   assign illegalOp      = (state_q == S_EVAL) & ~legal & ~reset;
   assign redirectValid  = redirectValid_q;
   assign redirectTarget = redirectTarget_q;
   assign linkAddress    = linkAddress_q;
   assign takenCount     = takenCount_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: handshakes, targets, link,
// reset-in-redirect, illegal op and counter saturation (8-bit counter).
module tb_branch_resolver;

   localparam int CB = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          issueValid;
   logic          issueReady;
   logic [3:0]    op;
   logic [31:0]   a;
   logic [31:0]   b;
   logic [31:0]   pc;
   logic [15:0]   offset;
   logic [25:0]   target26;
   logic          redirectValid;
   logic [31:0]   redirectTarget;
   logic          redirectAccept;
   logic          flush;
   logic          linkValid;
   logic [31:0]   linkAddress;
   logic          illegalOp;
   logic [CB-1:0] takenCount;

   int tests = 0;
   int fails = 0;

   branch_resolver #(
      .BITS(32), .ADDR_BITS(32), .COUNT_BITS(CB)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .issueValid     (issueValid),
      .issueReady     (issueReady),
      .op             (op),
      .a              (a),
      .b              (b),
      .pc             (pc),
      .offset         (offset),
      .target26       (target26),
      .redirectValid  (redirectValid),
      .redirectTarget (redirectTarget),
      .redirectAccept (redirectAccept),
      .flush          (flush),
      .linkValid      (linkValid),
      .linkAddress    (linkAddress),
      .illegalOp      (illegalOp),
      .takenCount     (takenCount)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] p,
                        input logic [15:0] off, input logic [25:0] t);
      op = o; a = av; b = bv; pc = p; offset = off; target26 = t;
      issueValid = 1'b1;
      step();
      issueValid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; issueValid = 1'b0; redirectAccept = 1'b0;
      op = '0; a = '0; b = '0; pc = '0; offset = '0; target26 = '0;
      step(); step();
      reset = 1'b0;
      chk("rst_ready", issueReady, 1);
      chk("rst_rv", redirectValid, 0);
      chk("rst_tgt", redirectTarget, 0);
      chk("rst_link", linkAddress, 0);
      chk("rst_cnt", takenCount, 0);
      chk("rst_pulses", {flush, linkValid, illegalOp}, 0);

      // BEQ taken
      issue(4'd0, 32'd5, 32'd5, 32'h0040_0000, 16'h0004, 26'd0);
      chk("beq_eval_ready", issueReady, 0);
      chk("beq_eval_rv", redirectValid, 0);
      step();
      chk("beq_rv", redirectValid, 1);
      chk("beq_tgt", redirectTarget, 32'h0040_0014);
      chk("beq_cnt", takenCount, 1);
      redirectAccept = 1'b1;
      #1;
      chk("beq_flush", flush, 1);
      step();
      redirectAccept = 1'b0;
      #1;
      chk("beq_done_rv", redirectValid, 0);
      chk("beq_done_ready", issueReady, 1);
      chk("beq_done_flush", flush, 0);

      // BNE not taken
      issue(4'd1, 32'd5, 32'd5, 32'h0000_0200, 16'h0010, 26'd0);
      chk("bne_eval_flush", flush, 0);
      step();
      chk("bne_rv", redirectValid, 0);
      chk("bne_ready", issueReady, 1);
      chk("bne_cnt", takenCount, 1);

      // BLTZAL not taken, still links
      issue(4'd6, 32'h0000_0001, 32'd0, 32'h0000_0100, 16'hFFFF, 26'd0);
      chk("bltzal_nt_link", linkValid, 1);
      chk("bltzal_nt_addr", linkAddress, 32'h108);
      step();
      chk("bltzal_nt_link_off", linkValid, 0);
      chk("bltzal_nt_rv", redirectValid, 0);
      chk("bltzal_nt_ready", issueReady, 1);

      // BLTZAL taken, backward offset
      issue(4'd6, 32'hFFFF_FFFF, 32'd0, 32'h0000_0100, 16'hFFFF, 26'd0);
      chk("bltzal_t_link", linkValid, 1);
      step();
      chk("bltzal_t_rv", redirectValid, 1);
      chk("bltzal_t_tgt", redirectTarget, 32'h100);
      chk("bltzal_t_cnt", takenCount, 2);
      redirectAccept = 1'b1;
      step();
      redirectAccept = 1'b0;

      // JAL with stalled accept; new issue must be ignored
      issue(4'd9, 32'd0, 32'd0, 32'h9000_0000, 16'd0, 26'h0000010);
      chk("jal_link", linkValid, 1);
      chk("jal_laddr", linkAddress, 32'h9000_0008);
      step();
      issue(4'd1, 32'd1, 32'd2, 32'h0000_1000, 16'd4, 26'd0);
      issueValid = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("jal_hold_rv", redirectValid, 1);
      chk("jal_hold_tgt", redirectTarget, 32'h9000_0040);
      chk("jal_hold_ready", issueReady, 0);
      chk("jal_hold_laddr", linkAddress, 32'h9000_0008);
      chk("jal_hold_cnt", takenCount, 3);
      issueValid = 1'b0;
      redirectAccept = 1'b1;
      #1;
      chk("jal_flush", flush, 1);
      step();
      redirectAccept = 1'b0;
      #1;
      chk("jal_done_rv", redirectValid, 0);
      chk("jal_done_ready", issueReady, 1);

      // reset while a redirect is pending
      issue(4'd8, 32'd0, 32'd0, 32'h0000_0000, 16'd0, 26'h0000040);
      step();
      chk("rr_rv_pre", redirectValid, 1);
      reset = 1'b1;
      redirectAccept = 1'b1;
      #1;
      chk("rr_no_flush", flush, 0);
      step();
      reset = 1'b0;
      redirectAccept = 1'b0;
      #1;
      chk("rr_rv", redirectValid, 0);
      chk("rr_ready", issueReady, 1);
      chk("rr_cnt", takenCount, 0);
      chk("rr_flush", flush, 0);

      // illegal op
      issue(4'd14, 32'd0, 32'd0, 32'h0000_0300, 16'd0, 26'd0);
      chk("ill_pulse", illegalOp, 1);
      chk("ill_nolink", linkValid, 0);
      step();
      chk("ill_off", illegalOp, 0);
      chk("ill_rv", redirectValid, 0);
      chk("ill_ready", issueReady, 1);

      // saturation of the taken counter
      redirectAccept = 1'b1;
      for (int i = 0; i < 254; i++) begin
         issue(4'd8, 32'd0, 32'd0, 32'h0000_0000, 16'd0, 26'd1);
         step(); step();
      end
      chk("sat_254", takenCount, 254);
      issue(4'd8, 32'd0, 32'd0, 32'h0000_0000, 16'd0, 26'd1);
      step(); step();
      chk("sat_255", takenCount, 255);
      for (int i = 0; i < 2; i++) begin
         issue(4'd8, 32'd0, 32'd0, 32'h0000_0000, 16'd0, 26'd1);
         step(); step();
      end
      chk("sat_hold", takenCount, 255);
      chk("sat_ready", issueReady, 1);
      redirectAccept = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
